// File: rtl/video_pattern_src.sv
// Raster test-pattern source: frame timing counters plus a pattern generator
// driving registered vs/hs/blank/RGB stream outputs on the en_i pixel strobe.
module video_pattern_src #(
    parameter int PIXEL_DEPTH = 8,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int GRID_LOG2   = 5
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [1:0]             mode_i,
    output logic                   vs_no,
    output logic                   hs_no,
    output logic                   blank_no,
    output logic                   en_o,
    output logic [PIXEL_DEPTH-1:0] output_R,
    output logic [PIXEL_DEPTH-1:0] output_G,
    output logic [PIXEL_DEPTH-1:0] output_B,
    output logic [7:0]             frame_cnt_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit so the sync-end bounds never alias when a total is a power of two.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [GRID_LOG2-1:0] GRID_MID = GRID_LOG2'(1 << (GRID_LOG2 - 1));

    logic [HW-1:0]          h_cnt;
    logic [VW-1:0]          v_cnt;
    logic [1:0]             mode_q;
    logic [7:0]             frame_q;

    logic                   h_wrap;
    logic                   v_wrap;
    logic                   frame_start;
    logic [1:0]             mode_eff;
    logic                   active;
    logic                   hs_act;
    logic                   vs_act;
    logic [2:0]             bar;
    logic [PIXEL_DEPTH-1:0] ramp;
    logic [PIXEL_DEPTH-1:0] pix_r;
    logic [PIXEL_DEPTH-1:0] pix_g;
    logic [PIXEL_DEPTH-1:0] pix_b;

    assign h_wrap      = (h_cnt == H_LAST);
    assign v_wrap      = (v_cnt == V_LAST);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    // The first pixel of a frame already shows the newly selected pattern.
    assign mode_eff    = frame_start ? mode_i : mode_q;

    assign active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs_act = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_act = (v_cnt >= VS_START) && (v_cnt < VS_END);

    assign frame_cnt_o = frame_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en_i) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= 2'd0;
            frame_q <= 8'd0;
        end else if (en_i) begin
            if (frame_start) begin
                mode_q <= mode_i;
            end
            if (h_wrap && v_wrap) begin
                frame_q <= frame_q + 8'd1;
            end
        end
    end

    always_comb begin
        bar   = 3'd0;
        ramp  = PIXEL_DEPTH'(h_cnt) + PIXEL_DEPTH'(frame_q);
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        // Bar index by threshold compare rather than a divider.
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= HW'(k * BAR_W)) begin
                bar = 3'(k);
            end
        end
        case (mode_eff)
            2'd0: begin
                if (h_cnt[GRID_LOG2] ^ v_cnt[GRID_LOG2]) begin
                    pix_r = '1;
                    pix_g = '1;
                    pix_b = '1;
                end
            end
            2'd1: begin
                pix_r = {PIXEL_DEPTH{~bar[1]}};
                pix_g = {PIXEL_DEPTH{~bar[2]}};
                pix_b = {PIXEL_DEPTH{~bar[0]}};
            end
            2'd2: begin
                pix_r = ramp;
                pix_g = ramp;
                pix_b = ramp;
            end
            default: begin
                if ((h_cnt[GRID_LOG2-1:0] == GRID_MID) && (v_cnt[GRID_LOG2-1:0] == GRID_MID)) begin
                    pix_r = '1;
                    pix_g = '1;
                    pix_b = '1;
                end
            end
        endcase
        if (!active) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_no    <= 1'b1;
            hs_no    <= 1'b1;
            blank_no <= 1'b0;
            output_R <= '0;
            output_G <= '0;
            output_B <= '0;
            en_o     <= 1'b0;
        end else begin
            en_o <= en_i;
            if (en_i) begin
                vs_no    <= ~vs_act;
                hs_no    <= ~hs_act;
                blank_no <= active;
                output_R <= pix_r;
                output_G <= pix_g;
                output_B <= pix_b;
            end
        end
    end
endmodule

// File: doc/video_pattern_src.md
Name: video_pattern_src

Overview:
- Raster video source that drives the same stream interface the filter blocks consume: vs/hs/blank (all active-low) plus RGB at PIXEL_DEPTH per channel.
- Generates full frame timing from parameterised counters and fills the active area with selectable test patterns.
- Sits upstream of the convolution and sliding-window blocks in place of the camera path.
- Used for bring-up and as a known stimulus for verifying the filters, including the impulse response.

Parameters:
- PIXEL_DEPTH, 8, bits per colour channel.
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- GRID_LOG2, 5, checker square size and impulse pitch, as log2 pixels.

Ports:
- clk  input  1  pixel-domain clock.
- rst_ni  input  1  asynchronous active-low reset.
- en_i  input  1  pixel strobe; the raster advances only on cycles with en_i=1.
- mode_i  input  2  pattern select; sampled at frame start only.
- vs_no  output  1  vertical sync, active-low.
- hs_no  output  1  horizontal sync, active-low.
- blank_no  output  1  low during blanking, high during active video.
- en_o  output  1  en_i delayed by one clk, aligned with the stream outputs.
- output_R  output  PIXEL_DEPTH  red channel.
- output_G  output  PIXEL_DEPTH  green channel.
- output_B  output  PIXEL_DEPTH  blue channel.
- frame_cnt_o  output  8  frame counter.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on rst_ni.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525).
- Counters: h_cnt counts 0..H_TOTAL-1 and v_cnt counts 0..V_TOTAL-1. Both change only when en_i=1.
  - h_cnt wraps to 0 at H_TOTAL-1, and v_cnt increments on that wrap.
  - v_cnt wraps to 0 at V_TOTAL-1 on the last h wrap of the frame.
- Decode from the current (h_cnt, v_cnt):
  - active = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hs low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vs changes together with h_cnt=0.
- Latency and hold:
  - All stream outputs are registered and load on en_i=1 cycles, one clk after the counter value they decode.
  - On en_i=0 cycles every output holds.
  - en_o is a plain one-cycle register of en_i.
- Frame start and mode:
  - The en_i cycle with h_cnt=0, v_cnt=0 loads mode_i into mode_q.
  - mode_i changes at any other time have no effect until the next frame start.
- Frame counter: frame_cnt_o increments on the en_i cycle where both counters wrap. It is modulo 256.
- Patterns, with x=h_cnt and y=v_cnt. Non-active pixels are forced to RGB=0.
  - mode 0, checker: white (all 1s) when x[GRID_LOG2] XOR y[GRID_LOG2] is 1, else black.
  - mode 1, colour bars: bar index = x / (H_ACTIVE/8), computed with a compare chain or counter, no divider. Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black. Channel levels are all 1s or 0.
  - mode 2, scrolling ramp: R=G=B=(x+frame_cnt)[PIXEL_DEPTH-1:0].
  - mode 3, impulse grid: white when x mod 2^GRID_LOG2 = 2^(GRID_LOG2-1) and likewise for y, else black.
- Reset values (any time, including mid-frame):
  - h_cnt=0, v_cnt=0, mode_q=0, frame_cnt_o=0.
  - vs_no=1, hs_no=1, blank_no=0, en_o=0, RGB=0.
  - The first frame after reset starts at (0,0) on the first en_i.
- Boundaries:
  - en_i is held low across a wrap: the counters do not move.
  - The sync decode uses half-open intervals, so widths are exactly H_SYNC pixels and V_SYNC lines.

Test Plan:
- Reset check: assert rst_ni=0 mid-line → outputs go immediately to vs_no=1, hs_no=1, blank_no=0, RGB=0, frame_cnt_o=0. After release, the first active pixel appears 1 clk after the first en_i.
- Timing with en_i constant 1 over 2 frames:
  - Each line has exactly 800 cycles with hs_no low for 96 cycles starting 656 cycles after blank_no rises.
  - Each frame has 525 lines with vs_no low for 2 lines.
  - blank_no is high for 640×480 pixels per frame.
  - frame_cnt_o steps 0→1→2.
- Mode 1 bar edges: pixel x=79 = (FF,FF,FF); x=80 = (FF,FF,00); x=639 = (00,00,00); x=640 = blanked 0.
- en_i gating: en_i toggles 1/0 randomly → output sequence is identical to the en_i=1 run when only en_o=1 samples are compared. Outputs are stable on en_i=0 cycles.
- Mode latching: mode_i 0→3 at line 100 → frame continues checker; next frame is impulse. (16,16)=FF, (17,16)=00, (48,48)=FF.
- Ramp scroll: mode 2 → in frame n, pixel x=0 = n mod 256 and x=255 = (255+n) mod 256. At frame_cnt_o=255 the counter wraps to 0 on the next frame.
